// File: rtl/register_file_pkg.sv
// Shared helpers for the register-file slice; nothing here depends on a particular
// block's parameters.
package register_file_pkg;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a producer issue and
// cleared by the matching write; two combinational lookup ports.
module reg_scoreboard
    import register_file_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_busy,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_busy
);

    logic [DEPTH-1:0] pending;

    logic set_ok, clr_ok, a_ok, b_ok;
    assign set_ok = set_en && addr_in_range(32'(set_addr), DEPTH);
    assign clr_ok = clr_en && addr_in_range(32'(clr_addr), DEPTH);
    assign a_ok   = addr_in_range(32'(a_addr), DEPTH);
    assign b_ok   = addr_in_range(32'(b_addr), DEPTH);

    // The set is scheduled after the clear so a same-address collision leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_ok) pending[clr_addr] <= 1'b0;
            if (set_ok) pending[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        a_busy = 1'b0;
        b_busy = 1'b0;
        if (a_ok) a_busy = pending[a_addr];
        if (b_ok) b_busy = pending[b_addr];
    end

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register file with two combinational read ports and a pending-write
// scoreboard. Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to reads.
module register_file
    import register_file_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [WIDTH-1:0]  ra_out,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [WIDTH-1:0]  rb_out,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              ra_busy,
    output logic              rb_busy
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             w_ok, ra_ok, rb_ok;
    logic             sb_a_busy, sb_b_busy;

    assign w_ok  = w_en && addr_in_range(32'(w_addr), DEPTH);
    assign ra_ok = addr_in_range(32'(ra_addr), DEPTH);
    assign rb_ok = addr_in_range(32'(rb_addr), DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (w_ok) begin
            regs[w_addr] <= d_in;
        end
    end

    // Every write retires the pending mark of its target register.
    reg_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (busy_set),
        .set_addr (busy_addr),
        .clr_en   (w_en),
        .clr_addr (w_addr),
        .a_addr   (ra_addr),
        .a_busy   (sb_a_busy),
        .b_addr   (rb_addr),
        .b_busy   (sb_b_busy)
    );

    always_comb begin
        ra_out  = '0;
        ra_busy = 1'b0;
        if (!rst && ra_ok) begin
            ra_out  = regs[ra_addr];
            ra_busy = sb_a_busy;
`ifdef REGISTER_FILE_BYPASS_EN
            if (w_en && (w_addr == ra_addr)) begin
                ra_out  = d_in;
                ra_busy = busy_set && (busy_addr == ra_addr);
            end
`endif
        end
    end

    always_comb begin
        rb_out  = '0;
        rb_busy = 1'b0;
        if (!rst && rb_ok) begin
            rb_out  = regs[rb_addr];
            rb_busy = sb_b_busy;
`ifdef REGISTER_FILE_BYPASS_EN
            if (w_en && (w_addr == rb_addr)) begin
                rb_out  = d_in;
                rb_busy = busy_set && (busy_addr == rb_addr);
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a default DEPTH=8 instance plus a DEPTH=6
// instance for out-of-range addressing.
module tb_register_file;

`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en, busy_set;
    logic [2:0] w_addr, ra_addr, rb_addr, busy_addr;
    logic [7:0] d_in, ra_out, rb_out;
    logic       ra_busy, rb_busy;

    logic       w_en6, busy_set6;
    logic [2:0] w_addr6, ra_addr6, rb_addr6, busy_addr6;
    logic [7:0] d_in6, ra_out6, rb_out6;
    logic       ra_busy6, rb_busy6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .d_in(d_in),
        .ra_addr(ra_addr), .ra_out(ra_out), .rb_addr(rb_addr), .rb_out(rb_out),
        .busy_set(busy_set), .busy_addr(busy_addr), .ra_busy(ra_busy), .rb_busy(rb_busy)
    );

    register_file #(.WIDTH(8), .DEPTH(6)) dut6 (
        .clk(clk), .rst(rst), .w_en(w_en6), .w_addr(w_addr6), .d_in(d_in6),
        .ra_addr(ra_addr6), .ra_out(ra_out6), .rb_addr(rb_addr6), .rb_out(rb_out6),
        .busy_set(busy_set6), .busy_addr(busy_addr6), .ra_busy(ra_busy6), .rb_busy(rb_busy6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        w_en = 0; w_addr = 0; d_in = 0; ra_addr = 0; rb_addr = 0; busy_set = 0; busy_addr = 0;
        w_en6 = 0; w_addr6 = 0; d_in6 = 0; ra_addr6 = 0; rb_addr6 = 0; busy_set6 = 0; busy_addr6 = 0;
        #1;
        check("por_ra_out", ra_out, 8'h00);
        check("por_ra_busy", ra_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Write r3=0xAA, mark it pending, then assert reset between edges
        w_en = 1; w_addr = 3; d_in = 8'hAA;
        tick();
        w_en = 0; ra_addr = 3;
        #1 check("r3_written", ra_out, 8'hAA);
        busy_set = 1; busy_addr = 3;
        tick();
        busy_set = 0;
        #1 check("r3_pending", ra_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", ra_out, 8'h00);
        check("async_rst_busy", ra_busy, 1'b0);

        // Writes and busy_set ignored while reset is held
        w_en = 1; w_addr = 3; d_in = 8'h55; busy_set = 1; busy_addr = 3;
        tick();
        check("rst_hold_data", ra_out, 8'h00);
        check("rst_hold_busy", ra_busy, 1'b0);
        busy_set = 0;
        w_addr = 0; d_in = 8'h12;
        rst = 1'b0;
        tick();
        w_en = 0; ra_addr = 0; rb_addr = 3;
        #1;
        check("first_write_after_rst", ra_out, 8'h12);
        check("r3_stays_clear", rb_out, 8'h00);
        check("r3_busy_clear", rb_busy, 1'b0);

        // Basic write/read on both ports
        w_en = 1; w_addr = 1; d_in = 8'h5A;
        tick();
        w_addr = 7; d_in = 8'hC3;
        tick();
        w_en = 0; ra_addr = 1; rb_addr = 7;
        #1;
        check("r1", ra_out, 8'h5A);
        check("r7", rb_out, 8'hC3);
        ra_addr = 2;
        #1 check("r2_untouched", ra_out, 8'h00);

        // Scoreboard set, re-set, clear, collisions
        busy_set = 1; busy_addr = 4;
        tick();
        busy_set = 0; ra_addr = 4; rb_addr = 4;
        #1;
        check("r4_busy_a", ra_busy, 1'b1);
        check("r4_busy_b", rb_busy, 1'b1);
        busy_set = 1;
        tick();
        busy_set = 0;
        #1 check("r4_reset_no_count", ra_busy, 1'b1);
        w_en = 1; w_addr = 4; d_in = 8'h11;
        tick();
        w_en = 0;
        #1;
        check("r4_clear_busy", ra_busy, 1'b0);
        check("r4_clear_data", ra_out, 8'h11);
        w_en = 1; w_addr = 4; d_in = 8'h22; busy_set = 1; busy_addr = 4;
        tick();
        w_en = 0; busy_set = 0;
        #1;
        check("r4_set_wins_busy", ra_busy, 1'b1);
        check("r4_set_wins_data", ra_out, 8'h22);
        w_en = 1; w_addr = 4; d_in = 8'h33; busy_set = 1; busy_addr = 6;
        tick();
        w_en = 0; busy_set = 0; rb_addr = 6;
        #1;
        check("diff_addr_r4_busy", ra_busy, 1'b0);
        check("diff_addr_r4_data", ra_out, 8'h33);
        check("diff_addr_r6_busy", rb_busy, 1'b1);
        check("diff_addr_r6_data", rb_out, 8'h00);

        // Same-cycle write/read of r5 (pending beforehand)
        busy_set = 1; busy_addr = 5;
        tick();
        busy_set = 0;
        w_en = 1; w_addr = 5; d_in = 8'h77; ra_addr = 5; rb_addr = 5;
        #1;
        check("bypass_data", ra_out, BYP ? 8'h77 : 8'h00);
        check("bypass_busy", ra_busy, BYP ? 1'b0 : 1'b1);
        busy_set = 1; busy_addr = 5;
        #1 check("bypass_busy_with_set", rb_busy, 1'b1);
        busy_set = 0;
        tick();
        w_en = 0;
        #1;
        check("r5_after_edge_data", ra_out, 8'h77);
        check("r5_after_edge_busy", ra_busy, 1'b0);

        // Dual port on same address
        w_en = 1; w_addr = 2; d_in = 8'h3C;
        tick();
        w_en = 0; ra_addr = 2; rb_addr = 2;
        #1;
        check("dual_a", ra_out, 8'h3C);
        check("dual_b", rb_out, 8'h3C);
        check("dual_busy_eq0", {ra_busy, rb_busy}, 2'b00);
        busy_set = 1; busy_addr = 2;
        tick();
        busy_set = 0;
        #1 check("dual_busy_eq1", {ra_busy, rb_busy}, 2'b11);

        // DEPTH=6 instance: out-of-range write/read/busy
        w_en6 = 1; w_addr6 = 5; d_in6 = 8'h05;
        tick();
        w_addr6 = 6; d_in6 = 8'hFF; busy_set6 = 1; busy_addr6 = 7;
        tick();
        w_en6 = 0; busy_set6 = 0;
        for (int i = 0; i < 6; i++) begin
            ra_addr6 = 3'(i);
            #1 check($sformatf("d6_r%0d", i), ra_out6, (i == 5) ? 8'h05 : 8'h00);
        end
        ra_addr6 = 7; rb_addr6 = 6;
        #1;
        check("d6_read7_data", ra_out6, 8'h00);
        check("d6_read7_busy", ra_busy6, 1'b0);
        check("d6_read6_data", rb_out6, 8'h00);
        check("d6_read6_busy", rb_busy6, 1'b0);
        busy_set6 = 1; busy_addr6 = 0;
        tick();
        busy_set6 = 0; ra_addr6 = 0;
        #1 check("d6_r0_busy", ra_busy6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 8, data bits per register.
REQ-002 Parameter DEPTH, default 8, number of registers; legal range 2..256.
REQ-003 Localparam ADDR_W = $clog2(DEPTH), address width; not overridable.
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 w_en  input  1  write enable; write occurs on posedge while high.
REQ-007 w_addr  input  ADDR_W  write address.
REQ-008 d_in  input  WIDTH  write data.
REQ-009 ra_addr  input  ADDR_W  read port A address.
REQ-010 ra_out  output  WIDTH  read port A data.
REQ-011 rb_addr  input  ADDR_W  read port B address.
REQ-012 rb_out  output  WIDTH  read port B data.
REQ-013 busy_set  input  1  marks busy_addr as pending a write (producer issued).
REQ-014 busy_addr  input  ADDR_W  register to mark pending.
REQ-015 ra_busy  output  1  pending bit of ra_addr.
REQ-016 rb_busy  output  1  pending bit of rb_addr.

Function
REQ-017 Storage SHALL be DEPTH x WIDTH flops plus DEPTH pending bits.
REQ-018 Posedge with w_en=1 and w_addr<DEPTH SHALL load d_in into register w_addr; no other register changes.
REQ-019 Reads SHALL be combinational, zero latency: ra_out/rb_out = stored value at ra_addr/rb_addr.
REQ-020 Both read ports SHALL be independent; same address on both returns identical data.
REQ-021 Address >= DEPTH (non-power-of-2 DEPTH): write ignored, read data 0, busy output 0, busy_set ignored.
REQ-022 Posedge with busy_set=1 SHALL set pending[busy_addr].
REQ-023 Posedge with w_en=1 SHALL clear pending[w_addr].
REQ-024 Simultaneous busy_set and w_en to same address: set wins, bit ends 1, data still written.
REQ-025 Simultaneous busy_set and w_en to different addresses: both take effect.
REQ-026 busy_set on an already-pending register SHALL leave it pending (no counting).
REQ-027 Write to non-pending register SHALL be legal; pending stays 0.

Reset
REQ-028 rst high SHALL immediately (no clock) force all registers to 0 and all pending bits to 0.
REQ-029 While rst high, writes and busy_set SHALL be ignored; read outputs SHALL be 0.
REQ-030 First write SHALL take effect on the first posedge after rst deasserts.

Configuration
REQ-031 Macro REGISTER_FILE_BYPASS_EN defined: if w_en=1 and read address equals w_addr (in range), read port SHALL return d_in and its busy output SHALL be 0 unless busy_set targets the same address in that cycle (then 1).
REQ-032 Macro undefined: no forwarding; read returns old value, new value visible the cycle after the posedge; busy output reflects stored bit only.

Structure
REQ-033 Shared package SHALL hold nothing block-specific; ADDR_W derivation stays local.
REQ-034 Pending scoreboard SHALL be a sub-module reg_scoreboard (DEPTH bits, set/clear ports, two lookup ports); data array stays in register_file.

Verification
REQ-035 Reset: write 0xAA to r3, assert rst mid-cycle -> ra_out(r3)=0 immediately, ra_busy=0, no clock needed.
REQ-036 Write/read: write r1=0x5A, r7=0xC3 -> next cycle ra_addr=1 gives 0x5A, rb_addr=7 gives 0xC3; r2 still 0.
REQ-037 Scoreboard: busy_set r4 -> ra_busy(4)=1; later w_en r4=0x11 -> ra_busy=0, ra_out=0x11; same-cycle set+write r4 -> busy=1, data=new.
REQ-038 Bypass: w_en r5=0x77 with ra_addr=5 in same cycle -> ra_out=0x77 when REGISTER_FILE_BYPASS_EN defined, old value (0) when undefined.
REQ-039 DEPTH=6: write addr 6 with 0xFF -> no register changes; read addr 7 -> 0, busy 0.
REQ-040 Dual port: ra_addr=rb_addr=2 after writing 0x3C -> both outputs 0x3C, both busy equal.
